// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-first bypass,
// optional hardwired-zero entry and a post-reset clear sweep gating ready.

// Per-read-port resolve: gating, zero register, bypass, then stored data.
module regfile_mp_rdport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = 6
) (
  input  logic                          ready,
  input  logic [AW-1:0]                 ra,
  input  logic [WIDTH-1:0]              mem_q,
  input  logic [NWRITE-1:0]             commit,
  input  logic [NWRITE-1:0][AW-1:0]     wa,
  input  logic [NWRITE-1:0][WIDTH-1:0]  wd,
  output logic [WIDTH-1:0]              rd
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // Lowest priority first so later assignments override; ascending port
  // order makes the highest committing write port win the bypass.
  always_comb begin
    rd = mem_q;
    for (int i = 0; i < NWRITE; i++)
      if (commit[i] && wa[i] == ra) rd = wd[i];
    if (ZERO_REG != 0 && ra == '0) rd = '0;
    if (!({1'b0, ra} < DEPTH_W))   rd = '0;
    if (!ready)                    rd = '0;
  end
endmodule

module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int NREAD    = 3,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int DBG_ADDR = 28,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    ready,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    wa,
  input  logic [NWRITE*WIDTH-1:0] wd,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*WIDTH-1:0]  rd,
  (* mark_debug = "true" *)
  output logic [WIDTH-1:0]        dbg_rd
);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                          state, state_n;
  logic [AW-1:0]                   cnt, cnt_n;
  logic [WIDTH-1:0]                mem [DEPTH];
  logic [NWRITE-1:0][AW-1:0]       wa_p;
  logic [NWRITE-1:0][WIDTH-1:0]    wd_p;
  logic [NREAD-1:0][AW-1:0]        ra_p;
  logic [NREAD-1:0][WIDTH-1:0]     rd_p;
  logic [NWRITE-1:0]               commit;

  assign wa_p   = wa;
  assign wd_p   = wd;
  assign ra_p   = ra;
  assign rd     = rd_p;
  assign ready  = (state == RUN);
  assign dbg_rd = mem[DBG_ADDR];

  // Sweep state and clear counter; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: step through every entry, then settle in RUN for good.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = RUN;
          cnt_n   = cnt;
        end
      end
      default: ;
    endcase
  end

  // A write commits only in RUN, in range, and not to the hardwired zero.
  always_comb begin
    commit = '0;
    for (int i = 0; i < NWRITE; i++)
      commit[i] = ready && we[i] && ({1'b0, wa_p[i]} < DEPTH_W) &&
                  !(ZERO_REG != 0 && wa_p[i] == '0);
  end

  // Storage has no reset; the sweep zeroes it. Later ports override earlier.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++)
        if (commit[i]) mem[wa_p[i]] <= wd_p[i];
    end
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    logic [WIDTH-1:0] mem_q;
    assign mem_q = mem[ra_p[j]];

    regfile_mp_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NWRITE(NWRITE),
      .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_rdport (
      .ready  (ready),
      .ra     (ra_p[j]),
      .mem_q  (mem_q),
      .commit (commit),
      .wa     (wa_p),
      .wd     (wd_p),
      .rd     (rd_p[j])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on three configurations sharing one
// stimulus bus (default, ZERO_REG=0, DEPTH=40; all have 6-bit addresses).
module tb_regfile_mp;
  localparam int W = 32, AW = 6, NR = 3, NW = 2;

  logic clk = 1'b0, rstn = 1'b0;
  logic [NW-1:0]    we = '0;
  logic [NW*AW-1:0] wa = '0;
  logic [NW*W-1:0]  wd = '0;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*W-1:0]  rd_a, rd_b, rd_c;
  logic [W-1:0]     dbg_a, dbg_b, dbg_c;
  logic             rdy_a, rdy_b, rdy_c;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (.clk(clk), .rstn(rstn), .ready(rdy_a), .we(we), .wa(wa),
    .wd(wd), .ra(ra), .rd(rd_a), .dbg_rd(dbg_a));
  regfile_mp #(.ZERO_REG(0)) u_nz (.clk(clk), .rstn(rstn), .ready(rdy_b),
    .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b), .dbg_rd(dbg_b));
  regfile_mp #(.DEPTH(40)) u_d40 (.clk(clk), .rstn(rstn), .ready(rdy_c),
    .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_c), .dbg_rd(dbg_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_ready", 32'(rdy_a), 0);
    chk("reset_rd", rd_a[0 +: W], 0);

    // Sweep with writes held on: must be ignored (and 45/63 are out of range for DEPTH=40).
    we = 2'b11; wa = {6'd63, 6'd45}; wd = {32'hFFFF_FFFF, 32'hFFFF_FFFF}; ra = {3{6'd45}};
    rstn = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk($sformatf("sweep_rdy64_e%0d", k), 32'(rdy_a), 32'(k == 64));
      chk($sformatf("sweep_rdy40_e%0d", k), 32'(rdy_c), 32'(k >= 40));
      if (k == 10) chk("sweep_rd_gated", rd_a[0 +: W], 0);
    end
    we = '0;
    for (int a = 0; a < 64; a++) begin
      ra[0 +: AW] = AW'(a);
      #1;
      chk($sformatf("post_sweep_e%0d", a), rd_a[0 +: W], 0);
      chk($sformatf("post_sweep40_e%0d", a), rd_c[0 +: W], 0);
    end

    // Basic write then read; port 2 aliases port 0.
    we = 2'b01; wa = {6'd0, 6'd5}; wd = {32'h0, 32'hDEAD_BEEF};
    tick();
    we = '0; ra = {6'd5, 6'd6, 6'd5};
    #1;
    chk("basic_rd0", rd_a[0 +: W], 32'hDEAD_BEEF);
    chk("basic_rd1", rd_a[W +: W], 0);
    chk("basic_rd2_alias", rd_a[2*W +: W], 32'hDEAD_BEEF);

    // Same-address conflict: bypass and commit both favour port 1.
    we = 2'b11; wa = {6'd9, 6'd9}; wd = {32'h22, 32'h11}; ra = {6'd0, 6'd9, 6'd9};
    #1;
    chk("bypass_hi_port", rd_a[0 +: W], 32'h22);
    chk("bypass_rd1", rd_a[W +: W], 32'h22);
    tick();
    we = '0;
    #1;
    chk("conflict_commit", rd_a[0 +: W], 32'h22);

    // Zero register: no bypass and no commit when ZERO_REG=1.
    we = 2'b01; wa = {6'd0, 6'd0}; wd = {32'h0, 32'hFFFF_FFFF}; ra = {6'd0, 6'd0, 6'd0};
    #1;
    chk("zero_bypass_z1", rd_a[0 +: W], 0);
    chk("zero_bypass_z0", rd_b[0 +: W], 32'hFFFF_FFFF);
    tick();
    we = '0;
    #1;
    chk("zero_after_z1", rd_a[0 +: W], 0);
    chk("zero_after_z0", rd_b[0 +: W], 32'hFFFF_FFFF);

    // Out-of-range address on DEPTH=40: dropped, reads 0, no alias into entry 5.
    we = 2'b01; wa = {6'd0, 6'd45}; wd = {32'h0, 32'hAAAA_5555}; ra = {6'd5, 6'd0, 6'd45};
    #1;
    chk("oor_bypass40", rd_c[0 +: W], 0);
    tick();
    we = '0;
    #1;
    chk("oor_after40", rd_c[0 +: W], 0);
    chk("oor_entry5_40", rd_c[2*W +: W], 32'hDEAD_BEEF);
    chk("oor_dbg40", dbg_c, 0);
    chk("inrange_45_64", rd_a[0 +: W], 32'hAAAA_5555);

    // Mid-run reset: entry 28 survives until the sweep reaches it.
    we = 2'b01; wa = {6'd0, 6'd28}; wd = {32'h0, 32'h1234}; ra = {3{6'd28}};
    tick();
    we = '0;
    #1;
    chk("dbg_written", dbg_a, 32'h1234);
    chk("rd_written", rd_a[0 +: W], 32'h1234);
    rstn = 1'b0;
    #1;
    chk("async_reset_ready", 32'(rdy_a), 0);
    chk("async_reset_rd", rd_a[0 +: W], 0);
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 10) begin
        chk("resweep10_ready", 32'(rdy_a), 0);
        chk("resweep10_rd", rd_a[0 +: W], 0);
        chk("resweep10_dbg", dbg_a, 32'h1234);
      end
      if (k == 28) chk("resweep28_dbg", dbg_a, 32'h1234);
      if (k == 29) chk("resweep29_dbg", dbg_a, 0);
      if (k == 63) chk("resweep63_ready", 32'(rdy_a), 0);
    end
    chk("resweep_ready", 32'(rdy_a), 1);
    chk("resweep_dbg", dbg_a, 0);
    chk("resweep_rd28", rd_a[0 +: W], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: successor to the single-write, single-read 64x32 file.
- Adds configurable width, depth and read/write port counts, plus write-first bypass, an optional hardwired-zero register and a post-reset clear sweep with a ready flag.
- Sits between the decode stage (read ports) and the writeback stage (write ports); the debug tap feeds ILA probing.

Parameters:
- WIDTH, 32, data bits per entry
- DEPTH, 64, number of entries (any value >= 2, not necessarily a power of two)
- NREAD, 3, number of read ports
- NWRITE, 2, number of write ports
- ZERO_REG, 1, if 1, entry 0 always reads 0 and writes to it are dropped
- DBG_ADDR, 28, entry mirrored on dbg_rd
- (localparam AW = clog2(DEPTH), address width)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rstn  in  1  reset, asynchronous, active-low
- ready  out  1  high once the clear sweep is done; writes accepted only when high
- we  in  NWRITE  per-port write enable
- wa  in  NWRITE*AW  write addresses; port i at bits [i*AW +: AW]
- wd  in  NWRITE*WIDTH  write data; port i at bits [i*WIDTH +: WIDTH]
- ra  in  NREAD*AW  read addresses, same packing as wa
- rd  out  NREAD*WIDTH  read data, same packing as wd
- dbg_rd  out  WIDTH  stored (unbypassed) contents of DBG_ADDR; carries mark_debug

Behaviour:
- Storage: DEPTH x WIDTH distributed RAM. Storage has no reset, so contents are zeroed by the sweep.
- FSM states are CLEAR and RUN.
  - rstn low: state=CLEAR, clear counter=0, ready=0, all asynchronous.
  - CLEAR: each posedge writes 0 to entry[counter] and increments counter.
  - On the edge that clears entry DEPTH-1, state goes to RUN and ready goes to 1. ready therefore rises exactly DEPTH posedges after rstn deasserts.
  - RUN has no exit except reset.
- Reset asserted mid-sweep or mid-run: immediate return to CLEAR with counter=0. The sweep restarts in full.
- Writes (RUN only):
  - On posedge, entry[wa_i] <= wd_i for each port i with we_i=1.
  - If several enabled ports target the same address, the highest port index wins.
  - In CLEAR, we is ignored.
  - Address >= DEPTH: write dropped.
  - ZERO_REG=1 and address 0: write dropped.
- Reads are combinational (zero latency). Priority, first match wins:
  1. ready=0 -> 0.
  2. ra_j >= DEPTH -> 0.
  3. ZERO_REG=1 and ra_j=0 -> 0.
  4. Any enabled write port with wa_i=ra_j that would commit this cycle -> wd of the highest such i (write-first bypass).
  5. Otherwise -> entry[ra_j].
- dbg_rd = entry[DBG_ADDR] with no bypass and no ready gating. It reads 0 only after the sweep has cleared that entry.
- Output reset values: ready=0; rd all 0 (forced by ready=0); dbg_rd undefined until the sweep clears DBG_ADDR.
- Any combination of read ports may alias each other or any write port.

Test Plan:
- Reset sweep: DEPTH=64, release rstn, count edges -> ready=0 for 63 edges and rises after edge 64. we=1 during the sweep is ignored, and all entries read 0 afterward.
- Basic write/read: write wa0=5, wd0=0xDEADBEEF, then ra0=5 next cycle -> rd0=0xDEADBEEF. ra1=6 -> 0.
- Bypass and conflict: same cycle we0=we1=1, wa0=wa1=9, wd0=0x11, wd1=0x22, ra0=9 -> rd0=0x22 combinationally; the following cycle, entry 9 reads 0x22.
- Zero register: ZERO_REG=1, write 0xFFFF_FFFF to address 0 -> rd=0 both in the same cycle (no bypass) and afterward. Repeat with ZERO_REG=0 -> reads 0xFFFF_FFFF.
- Non-power-of-two: DEPTH=40, write addr 45 -> no entry changes; ra=45 -> 0. Sweep length is 40 edges.
- Mid-operation reset: write 0x1234 to entry 28, pulse rstn low for 1 cycle, 10 edges into the re-sweep -> ready=0 and rd=0. After 64 edges dbg_rd=0 and entry 28 reads 0.
